// File: rtl/pc_sequencer.sv
// Program-flow controller: PC, stall sequencing, jump resolution and Start/Done handshake.
// Optional executed-cycle counter enabled by defining PC_SEQ_CYCLE_COUNT_EN.
module pc_sequencer #(
    parameter int PC_W         = 8,
    parameter int STALL_CYCLES = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Jen,
    input  logic [7:0]      Jptr,
    input  logic            Taken,
    input  logic            HaltReq,
    output logic [PC_W-1:0] Prog_ctr,
    output logic            ExecEn,
    output logic            Busy,
    output logic            Done,
    output logic [15:0]     CycleCnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STALL,
        HALT
    } state_t;

    localparam logic [2:0] STALL_LD = 3'(STALL_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nx;
    logic [2:0]      scnt;
    logic [2:0]      scnt_nx;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] jtgt;
    logic            done_nx;

    // Jump target: truncate or zero-extend the 8-bit decoder field.
    generate
        if (PC_W > 8) begin : g_jext
            assign jtgt = {{(PC_W-8){1'b0}}, Jptr};
        end else if (PC_W == 8) begin : g_jeq
            assign jtgt = Jptr;
        end else begin : g_jtrunc
            logic unused_jptr_hi;
            assign jtgt = Jptr[PC_W-1:0];
            assign unused_jptr_hi = ^Jptr[7:PC_W];
        end
    endgenerate

    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        pc_nx    = Prog_ctr;
        ExecEn   = 1'b0;
        unique case (state)
            IDLE: begin
                pc_nx = '0;
                if (Start) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                pc_nx = '0;
                if (!Start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (Start) begin
                    state_nx = LOAD;
                    scnt_nx  = '0;
                    pc_nx    = '0;
                end else if (Stall) begin
                    state_nx = STALL;
                    scnt_nx  = STALL_LD;
                end else begin
                    ExecEn = 1'b1;
                end
            end
            STALL: begin
                if (Start) begin
                    state_nx = LOAD;
                    scnt_nx  = '0;
                    pc_nx    = '0;
                end else if (scnt == 3'd0) begin
                    ExecEn = 1'b1;
                end else begin
                    scnt_nx = scnt - 3'd1;
                end
            end
            HALT: begin
                if (Start) begin
                    state_nx = LOAD;
                    pc_nx    = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                scnt_nx  = '0;
                pc_nx    = '0;
            end
        endcase

        // A halt request wins over any jump and freezes the PC.
        if (ExecEn) begin
            if (HaltReq) begin
                state_nx = HALT;
            end else begin
                state_nx = RUN;
                pc_nx = (Jen && Taken) ? jtgt : Prog_ctr + PC_ONE;
            end
        end
    end

    assign Busy    = (state == RUN) || (state == STALL);
    assign done_nx = (state_nx == HALT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            scnt     <= '0;
            Prog_ctr <= '0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nx;
            scnt     <= scnt_nx;
            Prog_ctr <= pc_nx;
            Done     <= done_nx;
        end
    end

`ifdef PC_SEQ_CYCLE_COUNT_EN
    logic [15:0] ccnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ccnt <= '0;
        end else if (state_nx == LOAD) begin
            ccnt <= '0;
        end else if (Busy && (ccnt != 16'hFFFF)) begin
            ccnt <= ccnt + 16'd1;
        end
    end

    assign CycleCnt = ccnt;
`else
    assign CycleCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: commit PCs are queued by the stimulus
// and checked by a monitor on every ExecEn; registered outputs checked directly.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Stall;
    logic        Jen;
    logic [7:0]  Jptr;
    logic        Taken;
    logic        HaltReq;
    logic [7:0]  Prog_ctr;
    logic        ExecEn;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCnt;

    int vectors = 0;
    int errors  = 0;
    int commits = 0;
    logic [7:0] exp_q[$];

    pc_sequencer #(
        .PC_W(8),
        .STALL_CYCLES(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Stall(Stall),
        .Jen(Jen),
        .Jptr(Jptr),
        .Taken(Taken),
        .HaltReq(HaltReq),
        .Prog_ctr(Prog_ctr),
        .ExecEn(ExecEn),
        .Busy(Busy),
        .Done(Done),
        .CycleCnt(CycleCnt)
    );

    always #5 Clk = ~Clk;

    function automatic int cc(input int v);
`ifdef PC_SEQ_CYCLE_COUNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each commit strobe must match the next queued PC.
    always @(negedge Clk) begin
        if (!Reset && ExecEn) begin
            commits++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit: unexpected ExecEn at pc 0x%0h, expected none",
                         Prog_ctr);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (Prog_ctr != e) begin
                    errors++;
                    $display("FAIL commit_pc: got 0x%0h, expected 0x%0h", Prog_ctr, e);
                end
            end
        end
    end

    task automatic drive(input logic st, input logic j, input logic [7:0] p,
                         input logic t, input logic h);
        Stall   = st;
        Jen     = j;
        Jptr    = p;
        Taken   = t;
        HaltReq = h;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Non-stall instruction committing at cur_pc, then PC must be nxt.
    task automatic instr(input logic [7:0] cur_pc, input logic j, input logic [7:0] p,
                         input logic t, input logic [7:0] nxt);
        drive(1'b0, j, p, t, 1'b0);
        exp_q.push_back(cur_pc);
        step();
        check("pc_next", int'(Prog_ctr), int'(nxt));
    endtask

    // Stalled instruction: PC holds for 3 edges, commits on the 4th.
    task automatic stalled(input logic [7:0] cur_pc, input logic j, input logic [7:0] p,
                           input logic t, input logic [7:0] nxt);
        drive(1'b1, j, p, t, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", int'(Prog_ctr), int'(cur_pc));
            check("stall_busy", int'(Busy), 1);
        end
        exp_q.push_back(cur_pc);
        step();
        check("stall_next", int'(Prog_ctr), int'(nxt));
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        check("rst_pc", int'(Prog_ctr), 0);
        check("rst_done", int'(Done), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_cnt", int'(CycleCnt), 0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_busy", int'(Busy), 0);
        end

        // Program 1: 0..3 sequential, halt at 4.
        Start = 1'b1;
        step();
        step();
        check("load_pc", int'(Prog_ctr), 0);
        check("load_busy", int'(Busy), 0);
        Start = 1'b0;
        step();
        check("run_busy", int'(Busy), 1);
        check("run_pc0", int'(Prog_ctr), 0);
        for (int i = 0; i < 4; i++) begin
            instr(8'(i), 1'b0, 8'h00, 1'b0, 8'(i + 1));
        end
        drive(1'b0, 1'b1, 8'h40, 1'b1, 1'b1);
        exp_q.push_back(8'h04);
        step();
        check("halt_done", int'(Done), 1);
        check("halt_pc", int'(Prog_ctr), 4);
        check("halt_busy", int'(Busy), 0);
        check("halt_cnt", int'(CycleCnt), cc(5));
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        check("halt_hold_pc", int'(Prog_ctr), 4);
        check("halt_hold_done", int'(Done), 1);

        // Program 2: stall, jumps, wrap, abort.
        Start = 1'b1;
        step();
        check("relaunch_done", int'(Done), 0);
        check("relaunch_pc", int'(Prog_ctr), 0);
        check("relaunch_cnt", int'(CycleCnt), 0);
        Start = 1'b0;
        step();
        instr(8'h00, 1'b0, 8'h00, 1'b0, 8'h01);
        instr(8'h01, 1'b0, 8'h00, 1'b0, 8'h02);
        stalled(8'h02, 1'b0, 8'h00, 1'b0, 8'h03);
        instr(8'h03, 1'b0, 8'h00, 1'b0, 8'h04);
        instr(8'h04, 1'b0, 8'h00, 1'b0, 8'h05);
        instr(8'h05, 1'b1, 8'h20, 1'b1, 8'h20);
        instr(8'h20, 1'b1, 8'h05, 1'b1, 8'h05);
        instr(8'h05, 1'b1, 8'h20, 1'b0, 8'h06);
        stalled(8'h06, 1'b1, 8'hFE, 1'b1, 8'hFE);
        instr(8'hFE, 1'b0, 8'h00, 1'b0, 8'hFF);
        instr(8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
        check("wrap_busy", int'(Busy), 1);
        instr(8'h00, 1'b1, 8'h09, 1'b1, 8'h09);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        check("abort_pre_pc", int'(Prog_ctr), 9);
        Start = 1'b1;
        step();
        check("abort_pc", int'(Prog_ctr), 0);
        check("abort_busy", int'(Busy), 0);
        check("abort_cnt", int'(CycleCnt), 0);
        Start = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check("rerun_busy", int'(Busy), 1);
        check("rerun_cnt", int'(CycleCnt), 0);
        instr(8'h00, 1'b0, 8'h00, 1'b0, 8'h01);
        check("rerun_cnt1", int'(CycleCnt), cc(1));

        // Reset asserted between edges while the stall counter reads 1.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        #1;
        Reset = 1'b1;
        #1;
        check("rst_mid_pc", int'(Prog_ctr), 0);
        check("rst_mid_exec", int'(ExecEn), 0);
        check("rst_mid_busy", int'(Busy), 0);
        check("rst_mid_done", int'(Done), 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_busy", int'(Busy), 0);
            check("post_rst_pc", int'(Prog_ctr), 0);
        end

        check("queue_drained", exp_q.size(), 0);
        check("commit_total", commits, 18);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the 9-bit-instruction core. It owns the program counter and sequences each instruction through one or more execute cycles, honouring the decoder's `stall` (multi-cycle load/store/move/cmp) and `Jen`/`Jptr` (branch) outputs. It also runs the top-level Start/Done handshake. It sits between instruction memory (address source) and the decoder/register file/data memory (commit gating via `ExecEn`).

## Interface
Parameters:
- `PC_W`, 8, program counter width; instruction memory depth is 2^PC_W.
- `STALL_CYCLES`, 1, extra cycles added to any instruction decoded with `stall`=1 (range 1..7).

Ports:
- `Clk` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Start` in 1: level; high = load/hold program at address 0; falling edge launches execution.
- `Stall` in 1: decoder `stall` for the current instruction.
- `Jen` in 1: decoder jump enable for the current instruction.
- `Jptr` in 8: decoder jump target, absolute; low `PC_W` bits used, zero-extended if `PC_W`>8.
- `Taken` in 1: branch condition from the compare result.
- `HaltReq` in 1: decoder `Done` for the current instruction.
- `Prog_ctr` out PC_W: instruction fetch address (registered).
- `ExecEn` out 1: commit strobe; register-file/data-memory writes take effect only when high.
- `Busy` out 1: high in RUN or STALL.
- `Done` out 1: registered; high in HALT.
- `CycleCnt` out 16: executed-cycle counter (see Configuration).

## Operation
FSM states: IDLE, LOAD, RUN, STALL, HALT.
- IDLE, reached by reset: `Prog_ctr`=0; waits for `Start`=1, then goes to LOAD.
- LOAD: `Prog_ctr` forced to 0, `Done`=0. When `Start`=0, goes to RUN.
- RUN:
  - If `Stall`=0: `ExecEn`=1 this cycle. Next PC is `Jptr` when `Jen`&`Taken`, otherwise `Prog_ctr`+1 modulo 2^PC_W. All-ones wraps to 0.
  - If `Stall`=1: `ExecEn`=0, PC holds, stall counter loads `STALL_CYCLES`-1, state goes to STALL.
- STALL: PC holds. Counter decrements each cycle. In the cycle the counter reads 0, `ExecEn`=1, the PC advances by the RUN rule using the `Jen`/`Taken` values of that cycle, and the state returns to RUN.
- HaltReq: sampled only in a cycle where `ExecEn`=1. If high, the PC does not advance and the next state is HALT. `HaltReq` has priority over a jump.
- HALT: `Done`=1, `ExecEn`=0, PC frozen at the halting instruction. Stays until `Start`=1, then goes to LOAD.
- `Start`=1 in RUN or STALL aborts the program: next state is LOAD, stall counter cleared, no `ExecEn` in that cycle.
- `ExecEn` and `Busy` are combinational from the state and counter. `Prog_ctr`, `Done` and `CycleCnt` are registered.

## Timing
- Reset asserted: all outputs go to 0 immediately, state goes to IDLE, stall counter is 0. Deassertion is synchronised by the surrounding design.
- Single-cycle instruction: 1 clock, PC updates on the same edge that commits it.
- Stalled instruction: 1+`STALL_CYCLES` clocks, with exactly one `ExecEn` pulse, in the last cycle.
- Start→first commit: `Start` falls before edge N, so the edge-N state is RUN at PC 0. First `ExecEn` is in cycle N (a non-stall instruction commits at edge N+1).
- `Done` rises on the edge after the halting commit. It falls on the edge after `Start` is sampled high.
- Simultaneous `Stall` and `Jen` in RUN: the stall is taken first and the jump resolves in the final STALL cycle.

## Configuration
- `PC_SEQ_CYCLE_COUNT_EN` defined:
  - `CycleCnt` increments on every clock in RUN or STALL.
  - Clears to 0 on entry to LOAD.
  - Saturates at 16'hFFFF.
  - Holds in HALT.
- Undefined: the counter logic is absent and `CycleCnt` is tied to 16'h0000.

## Test plan
- Reset mid-STALL (`STALL_CYCLES`=3, counter=1), `Reset` asserted between edges → immediately `Prog_ctr`=0, `Done`=0, `ExecEn`=0, `Busy`=0; after release, the FSM stays IDLE until `Start`.
- Start pulse; four non-stall instructions, then `HaltReq` at PC 4 → `Prog_ctr` sequence 0,1,2,3,4; five `ExecEn` pulses; `Done`=1 one edge later; PC stays 4; `CycleCnt`=5 with the macro, 0 without.
- `Stall`=1 at PC 2 with `STALL_CYCLES`=3 → PC holds at 2 for 4 cycles with a single `ExecEn` in the fourth cycle, then PC becomes 3.
- `Jen`=1 at PC 5 with `Jptr`=0x20: `Taken`=1 → next PC 0x20; `Taken`=0 → next PC 6.
- `PC_W`=8, non-stall instruction at PC 0xFF → next PC 0x00, `Busy` stays 1.
- `Start` raised while in STALL at PC 9 → next cycle LOAD with PC 0, no `ExecEn`; `Start` lowered → RUN from 0; `CycleCnt` restarts from 0.
